// File: rtl/imem_loader.sv
// imem_loader: turns the byte stream from the debug/UART receiver into
// byte writes on the fetch stage's instruction-memory write port.
// The fetch PC is held in reset while a program is loading. It is released
// when an aligned HALT word has been written or when the memory is full.
//
// Ports:
//   i_clock              system clock; everything changes on the rising edge
//   i_reset              synchronous, active-high reset
//   i_start              one-cycle pulse; starts a new load from IDLE or DONE
//   i_rx_valid/i_rx_data received byte strobe and byte
//   o_write_enable       one-cycle imem write strobe
//   o_write_data/addr    byte and byte address of the write; held between strobes
//   o_instru_mem_enable  imem enable, constant 1
//   o_pc_reset           holds the fetch PC at 0 while high
//   o_busy / o_done      high in LOAD / DONE
//   o_overflow           sticky: the memory filled up without a HALT word
//   o_word_count         complete words written in the current load
module imem_loader #(
  parameter int                      NB_MEM_WIDTH   = 8,
  parameter int                      NB_IMEM_DEPTH  = 8,
  parameter int                      NB_INSTRUCTION = 32,  // must be 4*NB_MEM_WIDTH
  parameter logic [NB_INSTRUCTION-1:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_rx_valid,
  input  logic [NB_MEM_WIDTH-1:0]  i_rx_data,
  output logic                     o_write_enable,
  output logic [NB_MEM_WIDTH-1:0]  o_write_data,
  output logic [NB_IMEM_DEPTH-1:0] o_write_addr,
  output logic                     o_instru_mem_enable,
  output logic                     o_pc_reset,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overflow,
  output logic [NB_IMEM_DEPTH-2:0] o_word_count
);

  localparam int NB_WC   = NB_IMEM_DEPTH - 1;
  localparam int NB_HOLD = NB_INSTRUCTION - NB_MEM_WIDTH;  // bytes kept before the 4th arrives

  localparam logic [NB_IMEM_DEPTH-1:0] PTR_ONE = 1;
  localparam logic [NB_WC-1:0]         WC_ONE  = 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                     r_state, w_next_state;
  logic [NB_IMEM_DEPTH-1:0]   r_ptr;
  logic [1:0]                 r_phase;
  logic [NB_HOLD-1:0]         r_word;
  logic                       r_write_enable;
  logic [NB_MEM_WIDTH-1:0]    r_write_data;
  logic [NB_IMEM_DEPTH-1:0]   r_write_addr;
  logic                       r_pc_reset;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_overflow;
  logic [NB_WC-1:0]           r_word_count;

  logic                       w_accept;
  logic                       w_start;
  logic [NB_INSTRUCTION-1:0]  w_word;
  logic                       w_halt;
  logic                       w_last;

  // Next-state and datapath decode
  always_comb begin
    w_accept     = 1'b0;
    w_start      = 1'b0;
    w_halt       = 1'b0;
    w_last       = 1'b0;
    w_next_state = r_state;
    // Big-endian: the stored three bytes plus the incoming one form the word.
    w_word       = {r_word, i_rx_data};
    case (r_state)
      IDLE, DONE: begin
        // A start wins over a simultaneous byte; that byte is dropped.
        if (i_start) begin
          w_start      = 1'b1;
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        w_accept = i_rx_valid;
        w_halt   = i_rx_valid && (r_phase == 2'd3) && (w_word == HALT_INSTR);
        w_last   = i_rx_valid && (r_ptr == '1);
        if (w_halt || w_last) w_next_state = DONE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_phase        <= '0;
      r_word         <= '0;
      r_write_enable <= 1'b0;
      r_write_data   <= '0;
      r_write_addr   <= '0;
      r_pc_reset     <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
      r_word_count   <= '0;
    end else begin
      r_state        <= w_next_state;
      r_write_enable <= w_accept;
      // Status flags are registered from the next state so they line up with
      // the state register (DONE shows in the same cycle as the final strobe).
      r_busy         <= (w_next_state == LOAD);
      r_done         <= (w_next_state == DONE);
      r_pc_reset     <= (w_next_state != DONE);

      if (w_start) begin
        r_ptr        <= '0;
        r_phase      <= '0;
        r_word       <= '0;
        r_word_count <= '0;
        r_overflow   <= 1'b0;
      end

      if (w_accept) begin
        r_write_data <= i_rx_data;
        r_write_addr <= r_ptr;
        r_word       <= w_word[NB_HOLD-1:0];
        r_phase      <= r_phase + 2'd1;
        // The pointer saturates at the top address; the load ends there anyway.
        if (r_ptr != '1) r_ptr <= r_ptr + PTR_ONE;
        if (r_phase == 2'd3) r_word_count <= r_word_count + WC_ONE;
        if (w_last && !w_halt) r_overflow <= 1'b1;
      end
    end
  end

  assign o_write_enable      = r_write_enable;
  assign o_write_data        = r_write_data;
  assign o_write_addr        = r_write_addr;
  assign o_instru_mem_enable = 1'b1;
  assign o_pc_reset          = r_pc_reset;
  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_overflow          = r_overflow;
  assign o_word_count        = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-sized instance for the load,
// HALT and reset cases and a 16-byte instance for the overflow case.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       we, imem_en, pc_reset, busy, done, ovf;
  logic [7:0] wdata, waddr;
  logic [6:0] wc;

  logic       start4 = 1'b0, valid4 = 1'b0;
  logic [7:0] data4 = '0;
  logic       we4, imem_en4, pcr4, busy4, done4, ovf4;
  logic [7:0] wdata4;
  logic [3:0] waddr4;
  logic [2:0] wc4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_loader u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_write_enable(we), .o_write_data(wdata), .o_write_addr(waddr),
    .o_instru_mem_enable(imem_en), .o_pc_reset(pc_reset), .o_busy(busy), .o_done(done),
    .o_overflow(ovf), .o_word_count(wc)
  );

  imem_loader #(.NB_IMEM_DEPTH(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst), .i_start(start4), .i_rx_valid(valid4), .i_rx_data(data4),
    .o_write_enable(we4), .o_write_data(wdata4), .o_write_addr(waddr4),
    .o_instru_mem_enable(imem_en4), .o_pc_reset(pcr4), .o_busy(busy4), .o_done(done4),
    .o_overflow(ovf4), .o_word_count(wc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // One byte strobe; checks the registered write one cycle later.
  task automatic send(input logic [7:0] d, input int a, input logic exp_done, input int exp_wc);
    @(negedge clk); rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1; rx_valid = 1'b0;
    chk("we", we, 1);
    chk("wdata", wdata, d);
    chk("waddr", waddr, a);
    chk("done", done, exp_done);
    chk("pc_reset", pc_reset, !exp_done);
    chk("word_count", wc, exp_wc);
  endtask

  // Byte offered while not loading: must not produce a strobe.
  task automatic send_ignored(input logic [7:0] d);
    @(negedge clk); rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1; rx_valid = 1'b0;
    chk("ignored_we", we, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_we", we, 0);
    end
  endtask

  logic [7:0] prog [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] mis  [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_reset", pc_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wc", wc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_imem_en", imem_en, 1);
    @(negedge clk); rst = 1'b0;

    // IDLE ignores bytes
    send_ignored(8'h5A);
    chk("idle_busy", busy, 0);

    // Basic back-to-back load ending in HALT
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_pc_reset", pc_reset, 1);
    for (int i = 0; i < 8; i++) send(prog[i], i, i == 7, (i + 1) / 4);
    chk("basic_busy", busy, 0);
    idle(1);
    chk("basic_done_hold", done, 1);
    chk("basic_pc_released", pc_reset, 0);
    chk("basic_addr_hold", waddr, 7);
    chk("basic_data_hold", wdata, 8'hFF);
    send_ignored(8'h11);
    chk("done_ignores_rx", done, 1);

    // Gapped load from DONE
    pulse_start();
    chk("reload_pc_reset", pc_reset, 1);
    chk("reload_done", done, 0);
    chk("reload_wc", wc, 0);
    for (int i = 0; i < 8; i++) begin
      send(prog[i], i, i == 7, (i + 1) / 4);
      if (i < 7) idle(3);
    end

    // FFFFFFFF straddling a word boundary is not a HALT
    pulse_start();
    for (int i = 0; i < 8; i++) send(mis[i], i, 1'b0, (i + 1) / 4);
    idle(2);
    chk("misalign_busy", busy, 1);
    chk("misalign_done", done, 0);
    chk("misalign_wc", wc, 2);
    // start during LOAD is ignored: the pointer keeps going
    pulse_start();
    chk("load_start_wc", wc, 2);
    send(8'h12, 8, 1'b0, 2);

    // Reset in the middle of a load
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) send(prog[i], i, 1'b0, 0);
    @(negedge clk); rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    @(posedge clk); #1; rx_valid = 1'b0;
    chk("midrst_we", we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pc_reset", pc_reset, 1);
    chk("midrst_waddr", waddr, 0);
    @(negedge clk); rst = 1'b0;
    send_ignored(8'h05);
    idle(2);

    // start and byte together in IDLE: start wins, byte dropped
    @(negedge clk); start = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1; start = 1'b0; rx_valid = 1'b0;
    chk("startwin_we", we, 0);
    chk("startwin_busy", busy, 1);
    send(8'h77, 0, 1'b0, 0);

    // Overflow on the 16-byte instance
    @(negedge clk); start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    chk("ovf_start_busy", busy4, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); valid4 = 1'b1; data4 = 8'h00;
      @(posedge clk); #1; valid4 = 1'b0;
      chk("ovf_we", we4, 1);
      chk("ovf_waddr", waddr4, i);
      chk("ovf_done", done4, i == 15);
      chk("ovf_flag", ovf4, i == 15);
      chk("ovf_wc", wc4, (i + 1) / 4);
    end
    @(negedge clk); valid4 = 1'b1; data4 = 8'h99;
    @(posedge clk); #1; valid4 = 1'b0;
    chk("ovf_17th_we", we4, 0);
    chk("ovf_17th_addr", waddr4, 15);
    chk("ovf_pc_released", pcr4, 0);
    chk("ovf_imem_en", imem_en4, 1);

    // Reload after overflow clears the sticky flags
    @(negedge clk); start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    chk("reload4_ovf", ovf4, 0);
    chk("reload4_wc", wc4, 0);
    chk("reload4_pc_reset", pcr4, 1);
    chk("reload4_done", done4, 0);
    @(negedge clk); valid4 = 1'b1; data4 = 8'h3C;
    @(posedge clk); #1; valid4 = 1'b0;
    chk("reload4_we", we4, 1);
    chk("reload4_addr", waddr4, 0);
    chk("reload4_data", wdata4, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream feeder of the fetch stage. Receives a program as a byte stream from the debug/UART receiver and writes it byte-by-byte into the fetch stage's instruction memory write port.
- Holds the PC in reset while loading. Releases the PC once a HALT word is written or the memory is full.
- Sits between the UART RX and the fetch stage's `i_write_enable`, `i_write_data`, `i_write_addr`, `i_instru_mem_enable` and `i_pc_reset`.

Parameters:
- NB_MEM_WIDTH, 8, byte width of an instruction memory location.
- NB_IMEM_DEPTH, 8, instruction memory address width; capacity is 2^NB_IMEM_DEPTH bytes.
- NB_INSTRUCTION, 32, instruction width; must equal 4*NB_MEM_WIDTH.
- HALT_INSTR, 32'hFFFF_FFFF, word that terminates a load.

Ports:
- i_clock  in  1  system clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle pulse; begins a new load.
- i_rx_valid  in  1  single-cycle strobe; i_rx_data holds a new byte.
- i_rx_data  in  NB_MEM_WIDTH  received byte.
- o_write_enable  out  1  one-cycle imem write strobe.
- o_write_data  out  NB_MEM_WIDTH  byte to write.
- o_write_addr  out  NB_IMEM_DEPTH  byte address to write.
- o_instru_mem_enable  out  1  imem enable; high in every state.
- o_pc_reset  out  1  holds the fetch PC at 0 while high.
- o_busy  out  1  high in LOAD.
- o_done  out  1  high in DONE.
- o_overflow  out  1  sticky; memory filled without a HALT word.
- o_word_count  out  NB_IMEM_DEPTH-1  complete words written in the current load.

Behaviour:
- Reset: state=IDLE, address ptr=0, byte phase=0, word shift reg=0.
- Reset values of outputs: o_write_enable=0, o_write_data=0, o_write_addr=0, o_pc_reset=1, o_busy=0, o_done=0, o_overflow=0, o_word_count=0, o_instru_mem_enable=1.
- Reset mid-load aborts immediately. No further write strobes occur. Already-written bytes stay in memory.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - o_pc_reset=1.
  - i_rx_valid is ignored.
  - i_start -> LOAD next edge; ptr=0, phase=0, o_word_count=0, o_overflow=0.
- LOAD:
  - o_pc_reset=1, o_busy=1.
  - Each i_rx_valid registers one write at the next edge: o_write_enable=1 for exactly one cycle, o_write_data=i_rx_data, o_write_addr=ptr.
  - On that write, ptr increments by 1 and phase increments mod 4.
  - Latency is 1 cycle from i_rx_valid to the write strobe. Back-to-back i_rx_valid every cycle is supported.
  - Byte order is big-endian: phase 0 byte goes to word[31:24], phase 3 byte to word[7:0].
  - The word is compared using the incoming byte combined with the 3 stored bytes, on the phase-3 cycle.
  - Phase-3 byte completes a word: o_word_count increments.
  - Completed word == HALT_INSTR -> DONE at the same edge as its last byte's write strobe.
  - ptr == 2^NB_IMEM_DEPTH-1 and a byte is accepted, with no HALT -> the write still occurs, then DONE with o_overflow=1. ptr does not wrap.
  - i_start during LOAD is ignored.
- DONE:
  - o_pc_reset=0, o_done=1, o_busy=0. o_write_enable stays 0 after the final strobe.
  - i_rx_valid is ignored.
  - i_start -> LOAD; same clearing as from IDLE. o_pc_reset goes back to 1 the next cycle.
- Simultaneous i_start and i_rx_valid in IDLE/DONE: start wins; the byte is dropped.
- o_write_data and o_write_addr hold their last values when not strobing.
- All outputs are registered except o_instru_mem_enable, which is constant 1.

Test Plan:
- Reset check: assert i_reset 2 cycles -> o_pc_reset=1, o_done=0, o_write_enable=0, o_write_addr=0, o_word_count=0.
- Basic load: i_start, then bytes 20,01,00,05 (ADDI) and FF,FF,FF,FF on consecutive cycles ->
  - 8 strobes at addrs 0..7 with matching data, each 1 cycle after its byte.
  - o_done=1 in the cycle of the addr-7 strobe; o_pc_reset=0 after; o_word_count=2.
- Gapped stream: same bytes with 3 idle cycles between each -> identical writes. No strobes in idle cycles.
- HALT only on alignment: bytes 00,FF,FF,FF,FF,00,00,00 -> no DONE (no aligned word equals HALT); stays LOAD with o_word_count=2.
- Overflow: NB_IMEM_DEPTH=4, stream 16 bytes of 00 ->
  - 16 strobes, addrs 0..15.
  - DONE with o_overflow=1, o_word_count=4. A 17th byte causes no strobe.
- Reset mid-load: i_reset after byte 3 of 8 -> no further strobes; IDLE; o_pc_reset=1.
- Reload from DONE: i_start -> o_overflow and o_word_count clear; o_pc_reset=1; writes restart at addr 0.
